lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, meaning data and address width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Valid  input  1  SHALL mean the execute-stage instruction is valid this cycle.
REQ-005 MemOp  input  2  SHALL encode 00 none, 01 load, 10 store, 11 reserved (treated as none).
REQ-006 MemSize  input  2  SHALL encode 00 byte, 01 half, 10 word, 11 reserved.
REQ-007 MemUnsigned  input  1  SHALL select zero-extension (1) or sign-extension (0) for loads.
REQ-008 ALUResult  input  WIDTH  SHALL be the effective byte address from the ALU.
REQ-009 WriteData  input  WIDTH  SHALL be the rs2 store data.
REQ-010 Stall  output  1  SHALL hold the pipeline while an access is in progress.
REQ-011 Done  output  1  SHALL pulse one cycle when an access completes or is rejected.
REQ-012 ReadData  output  WIDTH  SHALL be the extended load result, registered.
REQ-013 Misaligned  output  1  SHALL pulse with Done for a rejected access.
REQ-014 mem_req  output  1  SHALL request a data-memory transfer.
REQ-015 mem_we  output  1  SHALL mark the transfer as a write.
REQ-016 mem_addr  output  WIDTH  SHALL be the word-aligned address {addr[WIDTH-1:2],2'b00}.
REQ-017 mem_wdata / mem_be  output  WIDTH / 4  SHALL be the lane-replicated write data and byte enables.
REQ-018 mem_ack  input  1, mem_rdata  input  WIDTH  SHALL be the transfer completion and read word.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS, RESPOND.
REQ-020 In IDLE with Valid=1 and MemOp load/store, the block SHALL capture address, data, size, signedness and op.
REQ-021 Misalignment checks at acceptance SHALL cover half with addr[0]=1, word with addr[1:0]!=0, and MemSize=11; a misaligned access SHALL go to RESPOND with Misaligned=1 and no mem_req.
REQ-022 An aligned access SHALL go to ACCESS. In ACCESS: mem_req=1, mem_we=store. mem_be SHALL be byte 0001<<addr[1:0], half 0011<<{addr[1],0}, word 1111. mem_wdata SHALL be byte {4{b}}, half {2{h}}, word as-is.
REQ-023 All mem_* outputs SHALL stay stable from first assertion until mem_ack=1 is sampled; then ACCESS->RESPOND. mem_ack SHALL be ignored outside ACCESS.
REQ-024 On the ack cycle of a load, the block SHALL extract the byte/half lane selected by addr[1:0], extend it per MemUnsigned, and register it into ReadData.
REQ-025 ReadData SHALL hold until the next load completes; stores and misaligned accesses SHALL NOT change it.
REQ-026 RESPOND SHALL assert Done for exactly one cycle, then go to IDLE unconditionally, with no acceptance in RESPOND.
REQ-027 Stall SHALL be combinational: 1 in ACCESS, and 1 in IDLE when an access is being accepted; 0 in RESPOND.
REQ-028 Latency: with acceptance in cycle N and ack in N+1, Done SHALL occur in N+2. A misaligned access SHALL give Done in N+1 with Stall high in N only.
REQ-029 Valid=0 or MemOp none/reserved SHALL cause no action and Stall=0.

Reset
REQ-030 While rst_n=0, state SHALL be IDLE, and every output, including ReadData, SHALL be 0.
REQ-031 Asserting reset during ACCESS SHALL deassert mem_req immediately and abandon the transfer.

Structure
REQ-032 Package lsu_pkg SHALL hold the memop_t and memsize_t enums, the FSM state_t, and the encodings from REQ-005/006.
REQ-033 Combinational lane logic (byte enables, write replication, load extract/extend) SHALL be one sub-module, lsu_align, instantiated once.

Verification
REQ-034 sw addr 0x100 data 0xDEADBEEF, ack in the first ACCESS cycle -> mem_addr 0x100, be 1111, wdata 0xDEADBEEF, Done in N+2.
REQ-035 lb addr 0x103, mem_rdata 0x80FF1234 -> be 1000, ReadData 0xFFFFFF80; lbu at the same address -> 0x00000080.
REQ-036 lh addr 0x102, rdata 0x80017FFF -> ReadData 0xFFFF8001; sh addr 0x102 data 0x0000ABCD -> wdata 0xABCDABCD, be 1100.
REQ-037 lw addr 0x101 -> Misaligned and Done in N+1, mem_req never 1, ReadData unchanged.
REQ-038 ack delayed 3 cycles -> mem_* stable and Stall high for 4 cycles; rst_n low mid-ACCESS -> mem_req 0 at once, state IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// LSU shared types: memory op / size encodings and FSM states.
// Imported by the LSU top and its lane-alignment helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } memop_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } memsize_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ACCESS  = 2'b01,
        S_RESPOND = 2'b10
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// LSU lane logic: byte enables, store replication and
// load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       off_i,
    input  memsize_t         size_i,
    input  logic             uns_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [WIDTH-1:0] rdata_i,
    output logic [3:0]       be_o,
    output logic [WIDTH-1:0] wdata_o,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};

    // Select lanes for the access size and extend the load lane.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {(WIDTH/8){wdata_i[7:0]}};
                rdata_o = uns_i ?
                    {{(WIDTH-8){1'b0}}, shifted[7:0]} :
                    {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be_o    = 4'b0011 << {off_i[1], 1'b0};
                wdata_o = {(WIDTH/16){wdata_i[15:0]}};
                rdata_o = uns_i ?
                    {{(WIDTH-16){1'b0}}, shifted[15:0]} :
                    {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one access from execute, runs a
// req/ack transfer to data memory and reports Done/Misaligned.
module lsu
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Valid,
    input  logic [1:0]       MemOp,
    input  logic [1:0]       MemSize,
    input  logic             MemUnsigned,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] ReadData,
    output logic             Misaligned,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    state_t           state_q, state_d;
    memop_t           op_in, op_q;
    memsize_t         size_in, size_q;
    logic [WIDTH-1:0] addr_q, wdata_q, rd_q;
    logic             uns_q, mis_q;
    logic             accept, mis_now, in_acc;
    logic [3:0]       be;
    logic [WIDTH-1:0] wrep, rext;

    assign op_in   = memop_t'(MemOp);
    assign size_in = memsize_t'(MemSize);
    assign in_acc  = (state_q == S_ACCESS);

    // Reset gates acceptance so Stall reads 0 while rst_n is low.
    assign accept = rst_n && (state_q == S_IDLE) && Valid &&
                    (op_in == OP_LOAD || op_in == OP_STORE);

    assign mis_now = (size_in == SZ_RSVD) ||
                     (size_in == SZ_HALF && ALUResult[0]) ||
                     (size_in == SZ_WORD && ALUResult[1:0] != 2'b00);

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .off_i   (addr_q[1:0]),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .wdata_i (wdata_q),
        .rdata_i (mem_rdata),
        .be_o    (be),
        .wdata_o (wrep),
        .rdata_o (rext)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: misaligned accesses skip the memory transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:
                if (accept) state_d = mis_now ? S_RESPOND : S_ACCESS;
            S_ACCESS:
                if (mem_ack) state_d = S_RESPOND;
            S_RESPOND:
                state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
    end

    // Capture the access at acceptance; latch load data on ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            op_q    <= OP_NONE;
            mis_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            if (accept) begin
                addr_q  <= ALUResult;
                wdata_q <= WriteData;
                size_q  <= size_in;
                uns_q   <= MemUnsigned;
                op_q    <= op_in;
                mis_q   <= mis_now;
            end
            if (in_acc && mem_ack && op_q == OP_LOAD)
                rd_q <= rext;
        end
    end

    assign Stall      = in_acc || accept;
    assign Done       = (state_q == S_RESPOND);
    assign Misaligned = (state_q == S_RESPOND) && mis_q;
    assign ReadData   = rd_q;
    assign mem_req    = in_acc;
    assign mem_we     = in_acc && (op_q == OP_STORE);
    assign mem_addr   = in_acc ? {addr_q[WIDTH-1:2], 2'b00} : '0;
    assign mem_wdata  = in_acc ? wrep : '0;
    assign mem_be     = in_acc ? be : 4'b0000;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: expected results are queued at
// drive time and popped when Done is observed.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Valid;
    logic [1:0]  MemOp, MemSize;
    logic        MemUnsigned;
    logic [31:0] ALUResult, WriteData;
    logic        Stall, Done, Misaligned;
    logic [31:0] ReadData;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    typedef struct {
        logic        mis;
        logic [31:0] rd;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_rd;

    lsu #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Valid       (Valid),
        .MemOp       (MemOp),
        .MemSize     (MemSize),
        .MemUnsigned (MemUnsigned),
        .ALUResult   (ALUResult),
        .WriteData   (WriteData),
        .Stall       (Stall),
        .Done        (Done),
        .ReadData    (ReadData),
        .Misaligned  (Misaligned),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access: drive, answer the memory, compare at Done.
    task automatic run(input string nm, input logic [1:0] op,
                       input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int dly,
                       input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic [31:0] erd);
        exp_t e;
        logic mis;
        int   nreq;
        int   lat;
        bit   seen;
        mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
              (sz == 2'b10 && a[1:0] != 2'b00);
        if (!mis && op == 2'b01) model_rd = erd;
        e.mis = mis;
        e.rd  = model_rd;
        e.lat = mis ? 1 : dly + 2;
        sb.push_back(e);

        @(negedge clk);
        Valid = 1'b1; MemOp = op; MemSize = sz; MemUnsigned = uns;
        ALUResult = a; WriteData = wd; mem_rdata = rd;
        #1 check({nm, ":stall_acc"}, {31'b0, Stall}, 32'd1);
        @(posedge clk);
        #1 Valid = 1'b0; MemOp = 2'b00;
        nreq = 0; lat = 1; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (Done) begin
                seen = 1;
                e = sb.pop_front();
                check({nm, ":lat"}, lat, e.lat);
                check({nm, ":mis"}, {31'b0, Misaligned}, {31'b0, e.mis});
                check({nm, ":rd"}, ReadData, e.rd);
                check({nm, ":stall_rsp"}, {31'b0, Stall}, 32'd0);
                check({nm, ":req_rsp"}, {31'b0, mem_req}, 32'd0);
            end else begin
                check({nm, ":stall"}, {31'b0, Stall}, 32'd1);
                check({nm, ":req"}, {31'b0, mem_req}, {31'b0, !mis});
                check({nm, ":we"}, {31'b0, mem_we}, {31'b0, op == 2'b10});
                check({nm, ":addr"}, mem_addr, {a[31:2], 2'b00});
                check({nm, ":be"}, {28'b0, mem_be}, {28'b0, ebe});
                check({nm, ":wdata"}, mem_wdata, ewd);
                mem_ack = (nreq == dly);
                nreq++;
                @(posedge clk);
                #1 mem_ack = 1'b0;
                lat++;
            end
        end
        if (!seen) check({nm, ":timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        check({nm, ":done_pulse"}, {31'b0, Done}, 32'd0);
    endtask

    // Inputs that must not start an access.
    task automatic idle_case(input string nm, input logic v,
                             input logic [1:0] op);
        @(negedge clk);
        Valid = v; MemOp = op; MemSize = 2'b10; ALUResult = 32'h40;
        mem_ack = 1'b1;
        #1 check({nm, ":stall"}, {31'b0, Stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({nm, ":req"}, {31'b0, mem_req}, 32'd0);
        check({nm, ":done"}, {31'b0, Done}, 32'd0);
        Valid = 1'b0; MemOp = 2'b00; mem_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; Valid = 1'b0; MemOp = 2'b00; MemSize = 2'b00;
        MemUnsigned = 1'b0; ALUResult = '0; WriteData = '0;
        mem_ack = 1'b0; mem_rdata = '0; model_rd = '0;
        repeat (2) @(negedge clk);
        check("rst:stall", {31'b0, Stall}, 32'd0);
        check("rst:done", {31'b0, Done}, 32'd0);
        check("rst:rd", ReadData, 32'd0);
        check("rst:req", {31'b0, mem_req}, 32'd0);
        check("rst:addr", mem_addr, 32'd0);
        check("rst:be", {28'b0, mem_be}, 32'd0);
        rst_n = 1'b1;

        run("sw",   2'b10, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0,
            0, 4'b1111, 32'hDEADBEEF, 32'h0);
        run("lb",   2'b01, 2'b00, 0, 32'h103, 32'h0, 32'h80FF1234,
            0, 4'b1000, 32'h0, 32'hFFFFFF80);
        run("lbu",  2'b01, 2'b00, 1, 32'h103, 32'h0, 32'h80FF1234,
            0, 4'b1000, 32'h0, 32'h00000080);
        run("lh",   2'b01, 2'b01, 0, 32'h102, 32'h0, 32'h80017FFF,
            0, 4'b1100, 32'h0, 32'hFFFF8001);
        run("sh",   2'b10, 2'b01, 0, 32'h102, 32'h0000ABCD, 32'h5555AAAA,
            0, 4'b1100, 32'hABCDABCD, 32'h0);
        run("lw_mis", 2'b01, 2'b10, 0, 32'h101, 32'h0, 32'h11111111,
            0, 4'b0000, 32'h0, 32'h0);
        run("lw_dly", 2'b01, 2'b10, 0, 32'h200, 32'h0, 32'h12345678,
            3, 4'b1111, 32'h0, 32'h12345678);
        run("lhu",  2'b01, 2'b01, 1, 32'h100, 32'h0, 32'h0000F00D,
            1, 4'b0011, 32'h0, 32'h0000F00D);
        run("lh0",  2'b01, 2'b01, 0, 32'h100, 32'h0, 32'h0000F00D,
            0, 4'b0011, 32'h0, 32'hFFFFF00D);
        run("sb",   2'b10, 2'b00, 0, 32'h101, 32'h0000005A, 32'hFFFFFFFF,
            2, 4'b0010, 32'h5A5A5A5A, 32'h0);
        run("lh_mis", 2'b01, 2'b01, 0, 32'h101, 32'h0, 32'h0,
            0, 4'b0000, 32'h0, 32'h0);
        run("rsv_mis", 2'b10, 2'b11, 0, 32'h104, 32'h1, 32'h0,
            0, 4'b0000, 32'h0, 32'h0);
        run("lbu1", 2'b01, 2'b00, 1, 32'h101, 32'h0, 32'h0000CD00,
            0, 4'b0010, 32'h0, 32'h000000CD);

        idle_case("novalid", 1'b0, 2'b01);
        idle_case("opnone", 1'b1, 2'b00);
        idle_case("oprsvd", 1'b1, 2'b11);

        // Reset in the middle of an access abandons it at once.
        @(negedge clk);
        Valid = 1'b1; MemOp = 2'b01; MemSize = 2'b10;
        ALUResult = 32'h300; mem_rdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 Valid = 1'b0; MemOp = 2'b00;
        @(negedge clk);
        check("mid:req_before", {31'b0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid:req", {31'b0, mem_req}, 32'd0);
        check("mid:stall", {31'b0, Stall}, 32'd0);
        check("mid:rd", ReadData, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_rd = '0;
        @(negedge clk);
        check("mid:idle_stall", {31'b0, Stall}, 32'd0);
        check("mid:idle_done", {31'b0, Done}, 32'd0);
        run("post", 2'b01, 2'b10, 0, 32'h304, 32'h0, 32'h0BADC0DE,
            0, 4'b1111, 32'h0, 32'h0BADC0DE);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
